// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns: one 32-bit column per cycle through
// four GF(2^8) multiply-accumulate lanes, result held until downstream takes it.
module mix_columns_seq #(
    parameter bit INV_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inverse,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; valid never depends on ready, and ready never depends on valid.
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [1:0]   col;
    logic         mode;
    logic [127:0] work;
    logic [127:0] result;
    logic [31:0]  col_in;
    logic [31:0]  col_out;
    logic [7:0]   lane_acc;
    logic [3:0]   coef [4];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Coefficients never exceed 0x0e, so four shift-and-add steps suffice.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (col == 2'd3) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        case (col)
            2'd0:    col_in = work[127:96];
            2'd1:    col_in = work[95:64];
            2'd2:    col_in = work[63:32];
            default: col_in = work[31:0];
        endcase
    end

    always_comb begin
        if (mode) coef = '{4'he, 4'hb, 4'hd, 4'h9};
        else      coef = '{4'h2, 4'h3, 4'h1, 4'h1};
    end

    // Row r uses the base coefficients rotated right by r.
    always_comb begin
        col_out  = 32'h0;
        lane_acc = 8'h00;
        for (int r = 0; r < 4; r++) begin
            lane_acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
                lane_acc = lane_acc ^ gf_mul(col_in[31-8*j -: 8], coef[2'(j - r)]);
            end
            col_out[31-8*r -: 8] = lane_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            col    <= 2'd0;
            mode   <= 1'b0;
            work   <= 128'h0;
            result <= 128'h0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        work <= state_in;
                        mode <= inverse & INV_EN;
                        col  <= 2'd0;
                    end
                end
                BUSY: begin
                    case (col)
                        2'd0:    result[127:96] <= col_out;
                        2'd1:    result[95:64]  <= col_out;
                        2'd2:    result[63:32]  <= col_out;
                        default: result[31:0]   <= col_out;
                    endcase
                    col <= col + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign state_out = result;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: vector table, backpressure, mid-operation
// reset and back-to-back streaming, against an inverse-enabled and a forward-only DUT.
module tb_mix_columns_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         inverse;
    logic [127:0] state_in;
    logic         out_ready;
    logic         in_ready0, out_valid0, in_ready1, out_valid1;
    logic [127:0] state_out0, state_out1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_q[$];

    typedef struct {
        logic [127:0] din;
        logic         inv;
        logic [127:0] exp0;
        logic         chk0;
        logic [127:0] exp1;
        logic         chk1;
    } vec_t;

    vec_t vecs[5];

    mix_columns_seq #(.INV_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .inverse(inverse), .state_in(state_in), .out_valid(out_valid0),
        .out_ready(out_ready), .state_out(state_out0)
    );

    mix_columns_seq #(.INV_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .inverse(inverse), .state_in(state_in), .out_valid(out_valid1),
        .out_ready(out_ready), .state_out(state_out1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!in_ready0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " in_ready"}, 128'(in_ready0), 128'(1));
    endtask

    task automatic accept(input logic [127:0] din, input logic inv);
        state_in = din;
        inverse  = inv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        state_in = ~din;
        inverse  = ~inv;
    endtask

    task automatic wait_done(input string name);
        int lat;
        lat = 0;
        while (!out_valid0 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, 128'(lat), 128'(4));
        check({name, " dut1 out_valid"}, 128'(out_valid1), 128'(1));
    endtask

    task automatic release_out(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, " out_valid drop"}, 128'(out_valid0), 128'(0));
        check({name, " in_ready back"}, 128'(in_ready0), 128'(1));
    endtask

    task automatic run_vector(input int id, input vec_t v);
        string name;
        name = $sformatf("vec%0d", id);
        wait_ready(name);
        accept(v.din, v.inv);
        wait_done(name);
        if (v.chk0) check({name, " dut0 state_out"}, state_out0, v.exp0);
        if (v.chk1) check({name, " dut1 state_out"}, state_out1, v.exp1);
        release_out(name);
    endtask

    // ---------------- test sequence ----------------
    logic [127:0] bb_in  [3];
    logic [127:0] bb_exp [3];

    initial begin
        logic [127:0] v1_in, v1_out, v2_in, v2_out, got;
        int accepts, got_n, last, pending;

        v1_in  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        v1_out = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        v2_in  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
        v2_out = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

        vecs[0] = '{din: v1_in, inv: 1'b0, exp0: v1_out, chk0: 1'b1, exp1: v1_out, chk1: 1'b1};
        vecs[1] = '{din: v2_in, inv: 1'b0, exp0: v2_out, chk0: 1'b1, exp1: v2_out, chk1: 1'b1};
        // Inverse of the forward images of columns d4d4d4d5 and 2d26314c.
        vecs[2] = '{din: 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, inv: 1'b1,
                    exp0: 128'hdb135345_f20a225c_d4d4d4d5_2d26314c, chk0: 1'b1,
                    exp1: 128'h0, chk1: 1'b0};
        vecs[3] = '{din: v1_out, inv: 1'b1, exp0: v1_in, chk0: 1'b1,
                    exp1: 128'h0, chk1: 1'b0};
        // Forward-only instance ignores inverse=1.
        vecs[4] = '{din: v1_in, inv: 1'b1, exp0: 128'h0, chk0: 1'b0,
                    exp1: v1_out, chk1: 1'b1};

        bb_in[0]  = v1_in;
        bb_in[1]  = v2_in;
        bb_in[2]  = 128'hc6c6c6c6_01010101_d4d4d4d5_db135345;
        bb_exp[0] = v1_out;
        bb_exp[1] = v2_out;
        bb_exp[2] = 128'hc6c6c6c6_01010101_d5d5d7d6_8e4da1bc;

        rst = 1'b1; in_valid = 1'b0; inverse = 1'b0; state_in = 128'h0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 128'(in_ready0), 128'(1));
        check("reset out_valid", 128'(out_valid0), 128'(0));
        check("reset state_out", state_out0, 128'h0);
        check("reset dut1 in_ready", 128'(in_ready1), 128'(1));
        check("reset dut1 state_out", state_out1, 128'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_vector(i, vecs[i]);

        // Backpressure: result must hold while downstream stalls.
        wait_ready("bp");
        accept(v2_in, 1'b0);
        wait_done("bp");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            inverse  = 1'($urandom_range(0, 1));
            state_in = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check($sformatf("bp%0d out_valid", i), 128'(out_valid0), 128'(1));
            check($sformatf("bp%0d in_ready", i), 128'(in_ready0), 128'(0));
            check($sformatf("bp%0d state_out", i), state_out0, v2_out);
        end
        in_valid = 1'b0;
        release_out("bp");

        // Reset during the second BUSY cycle discards the partial result.
        wait_ready("rst");
        accept(v1_in, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst in_ready", 128'(in_ready0), 128'(1));
        check("midrst out_valid", 128'(out_valid0), 128'(0));
        check("midrst state_out", state_out0, 128'h0);
        run_vector(10, vecs[0]);

        // Back-to-back streaming with in_valid and out_ready held high.
        accepts = 0; got_n = 0; last = 0; pending = 0;
        @(posedge clk); #1;
        state_in = bb_in[0]; inverse = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && got_n < 3; cyc++) begin
            @(negedge clk);
            if (pending != 0) begin
                if (accepts == 3) in_valid = 1'b0;
                else state_in = bb_in[accepts];
                pending = 0;
            end
            if (out_valid0 && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL b2b extra output: got %h expected none", state_out0);
                end else begin
                    got = exp_q.pop_front();
                    check($sformatf("b2b%0d dut0 state_out", got_n), state_out0, got);
                    check($sformatf("b2b%0d dut1 state_out", got_n), state_out1, got);
                end
                got_n++;
            end
            if (in_valid && in_ready0) begin
                if (accepts > 0) check($sformatf("b2b%0d spacing", accepts), 128'(cyc - last), 128'(6));
                last = cyc;
                exp_q.push_back(bb_exp[accepts]);
                accepts++;
                pending = 1;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b accepts", 128'(accepts), 128'(3));
        check("b2b outputs", 128'(got_n), 128'(3));
        check("b2b queue empty", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
